pipelined_control_unit: RTL and testbench

Control side of the five-stage RV64I datapath. It consumes opcode/func3/func7 and the register fields from the decode stage, and drives the per-instruction control bundle into the decode pipeline register. The datapath has no forwarding, so the block keeps a shadow copy of the destination registers still in flight in execute and memory, and from it generates RAW stalls, branch-taken flushes, a saturating stall counter and a sticky illegal-instruction flag.

---
 rtl/pipelined_ctrl_pkg.sv | 55 +++++
 rtl/pipelined_control_unit_decoder.sv | 89 ++++++++
 rtl/pipelined_control_unit.sv | 98 +++++++++
 tb/tb_pipelined_control_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipelined_ctrl_pkg.sv
// Shared encodings for the RV64I control unit: opcodes, ALU codes, control bundle, shadow stage.
package pipelined_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_op_e     alu_control;
    logic        alu_src;
    imm_src_e    imm_src;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       valid;
  } shadow_t;

  // func3 -> ALU op for the non-alternate R/I encodings
  function automatic alu_op_e f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // in-flight writer that a reader of register r must wait for
  function automatic logic hit(input shadow_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.rd != 5'd0) && (s.rd == r);
  endfunction
endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational main decoder: opcode/func fields to control bundle, source-use flags and illegal strobe.
module main_decoder
  import pipelined_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       illegal
);
  always_comb begin
    ctrl    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (func7 == 7'b0000000)                          ctrl.alu_control = f3_alu(func3);
        else if (func7 == 7'b0100000 && func3 == 3'b000) ctrl.alu_control = ALU_SUB;
        else if (func7 == 7'b0100000 && func3 == 3'b101) ctrl.alu_control = ALU_SRA;
        else                                              illegal = 1'b1;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        use_rs1 = 1'b1;
        ctrl.alu_control = f3_alu(func3);
        // RV64 shift amounts are 6 bits, so only func7[6:1] qualifies the shift
        if (func3 == 3'b001 && func7[6:1] != 6'b000000) illegal = 1'b1;
        if (func3 == 3'b101) begin
          if (func7[6:1] == 6'b010000)      ctrl.alu_control = ALU_SRA;
          else if (func7[6:1] != 6'b000000) illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        use_rs1 = 1'b1;
        if (func3 == 3'b111) illegal = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (func3[2]) illegal = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
        ctrl.imm_src     = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (func3[2:1] != 2'b00) illegal = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
      end
      OP_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        use_rs1 = 1'b1;
        if (func3 != 3'b000) illegal = 1'b1;
      end
      7'b0000000: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl    = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// Decode-stage control for the no-forwarding 5-stage pipeline: RAW stalls from a shadow of EX/MEM
// destinations, branch flush, saturating stall counter and sticky illegal flag.
module pipelined_control_unit
  import pipelined_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int XLEN        = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [6:0]             opcode,
  input  logic [2:0]             func3,
  input  logic [6:0]             func7,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [4:0]             rd,
  input  logic                   pc_source_execute,
  output logic                   reg_write,
  output logic [1:0]             result_src,
  output logic                   mem_write,
  output logic                   jump,
  output logic                   branch,
  output logic [3:0]             alu_control,
  output logic                   alu_src,
  output logic [1:0]             imm_src,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   flush_d,
  output logic                   illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);
  if (XLEN != 64 && XLEN != 32) begin : g_xlen_chk
    $error("pipelined_control_unit: XLEN must be 32 or 64");
  end

  ctrl_t   dec, ctrl;
  logic    use_rs1, use_rs2, dec_illegal;
  logic    raw, stall, flush;
  shadow_t e_sh, m_sh;
  logic    illegal_q;
  logic [STALL_CNT_W-1:0] cnt;

  main_decoder u_dec (
    .opcode  (opcode),
    .func3   (func3),
    .func7   (func7),
    .ctrl    (dec),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .illegal (dec_illegal)
  );

  // writeback is not checked: the register file writes in the first half-cycle
  assign raw   = (use_rs1 && (hit(e_sh, rs1) || hit(m_sh, rs1))) ||
                 (use_rs2 && (hit(e_sh, rs2) || hit(m_sh, rs2)));
  assign flush = pc_source_execute;
  assign stall = raw && !flush;

  always_comb begin
    ctrl = dec;
    if (flush) begin
      ctrl = '0;
    end else if (stall) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.branch    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e_sh      <= '0;
      m_sh      <= '0;
      illegal_q <= 1'b0;
      cnt       <= '0;
    end else begin
      e_sh      <= '{rd: rd, reg_write: ctrl.reg_write, valid: !(stall || flush)};
      m_sh      <= e_sh;
      if (dec_illegal) illegal_q <= 1'b1;
      if (stall && (cnt != {STALL_CNT_W{1'b1}})) cnt <= cnt + 1'b1;
    end
  end

  assign reg_write   = ctrl.reg_write;
  assign result_src  = ctrl.result_src;
  assign mem_write   = ctrl.mem_write;
  assign jump        = ctrl.jump;
  assign branch      = ctrl.branch;
  assign alu_control = ctrl.alu_control;
  assign alu_src     = ctrl.alu_src;
  assign imm_src     = ctrl.imm_src;
  assign stall_f     = stall;
  assign stall_d     = stall;
  assign flush_d     = flush;
  assign illegal     = illegal_q;
  assign stall_count = cnt;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit; a narrow-counter second instance covers saturation.
module tb_pipelined_control_unit;
  localparam int SAT_W = 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic [4:0] rs1, rs2, rd;
  logic       pc_source_execute;

  logic       reg_write, mem_write, jump, branch, alu_src, stall_f, stall_d, flush_d, illegal;
  logic [1:0] result_src, imm_src;
  logic [3:0] alu_control;
  logic [15:0] stall_count;

  logic       s_reg_write, s_mem_write, s_jump, s_branch, s_alu_src, s_stall_f, s_stall_d, s_flush_d, s_illegal;
  logic [1:0] s_result_src, s_imm_src;
  logic [3:0] s_alu_control;
  logic [SAT_W-1:0] s_stall_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipelined_control_unit #(.STALL_CNT_W(16), .XLEN(64)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .pc_source_execute(pc_source_execute),
    .reg_write(reg_write), .result_src(result_src), .mem_write(mem_write), .jump(jump),
    .branch(branch), .alu_control(alu_control), .alu_src(alu_src), .imm_src(imm_src),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .illegal(illegal),
    .stall_count(stall_count)
  );

  pipelined_control_unit #(.STALL_CNT_W(SAT_W), .XLEN(64)) dut_sat (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .pc_source_execute(pc_source_execute),
    .reg_write(s_reg_write), .result_src(s_result_src), .mem_write(s_mem_write), .jump(s_jump),
    .branch(s_branch), .alu_control(s_alu_control), .alu_src(s_alu_src), .imm_src(s_imm_src),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .illegal(s_illegal),
    .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; rd = d;
    #1;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      instr(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    pc_source_execute = 1'b0;
    opcode = '0; func3 = '0; func7 = '0; rs1 = '0; rs2 = '0; rd = '0;
    #12;
    chk("rst_stall_count", 32'(stall_count), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_bubble_ctrl", {reg_write, mem_write, jump, branch, stall_f, flush_d}, 0);
    reset_n = 1'b1;
    tick();

    // add x3,x1,x2
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3);
    chk("add_reg_write", 32'(reg_write), 1);
    chk("add_alu", 32'(alu_control), 32'h0);
    chk("add_alu_src", 32'(alu_src), 0);
    chk("add_no_stall", 32'(stall_f), 0);
    tick();
    chk("add_count", 32'(stall_count), 0);
    bubble(2);

    // ld x5,0(x1) ; add x6,x5,x7
    instr(7'b0000011, 3'b011, 7'd0, 5'd1, 5'd0, 5'd5);
    chk("ld_ctrl", {reg_write, result_src, alu_src}, 32'b1011);
    tick();
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd7, 5'd6);
    chk("raw1_stall", {stall_f, stall_d}, 32'b11);
    chk("raw1_bubble", {reg_write, mem_write, jump, branch}, 0);
    tick();
    chk("raw2_stall", {stall_f, stall_d}, 32'b11);
    chk("raw2_bubble", 32'(reg_write), 0);
    tick();
    chk("raw_release", {stall_f, stall_d, reg_write}, 32'b001);
    chk("raw_count", 32'(stall_count), 2);
    tick();
    bubble(2);

    // addi x0,x0,1 ; add x1,x0,x0
    instr(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("addi_ctrl", {reg_write, alu_src, imm_src}, 32'b1100);
    tick();
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd1);
    chk("x0_no_stall", 32'(stall_f), 0);
    tick();
    bubble(2);

    // decode spot checks, rd=0 so nothing becomes a hazard
    instr(7'b0110011, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd0);
    chk("sub_alu", 32'(alu_control), 32'h1);
    instr(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd0, 5'd0);
    chk("srai_alu", {alu_control, alu_src}, 32'b01111);
    instr(7'b0110011, 3'b111, 7'b0000000, 5'd1, 5'd2, 5'd0);
    chk("and_alu", 32'(alu_control), 32'h2);
    instr(7'b0100011, 3'b011, 7'd0, 5'd1, 5'd2, 5'd0);
    chk("sd_ctrl", {reg_write, mem_write, alu_src, imm_src, alu_control}, 32'b0110_1_0000);
    instr(7'b1101111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0);
    chk("jal_ctrl", {jump, reg_write, result_src, imm_src}, 32'b111011);
    instr(7'b1100111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0);
    chk("jalr_ctrl", {jump, reg_write, result_src, alu_src, alu_control}, 32'b1110_1_0000);
    tick();
    bubble(2);

    // beq, then ld x5, then dependent add arriving with a taken branch in execute
    instr(7'b1100011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0);
    chk("beq_ctrl", {branch, reg_write, alu_control, imm_src}, 32'b1_0_0001_10);
    tick();
    instr(7'b0000011, 3'b011, 7'd0, 5'd1, 5'd0, 5'd5);
    tick();
    pc_source_execute = 1'b1;
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd7, 5'd6);
    chk("flush_d", 32'(flush_d), 1);
    chk("flush_no_stall", {stall_f, stall_d}, 0);
    chk("flush_zero", {reg_write, result_src, mem_write, jump, branch, alu_control, alu_src, imm_src}, 0);
    tick();
    pc_source_execute = 1'b0;
    chk("flush_count", 32'(stall_count), 2);
    bubble(2);

    // lui is unsupported
    instr(7'b0110111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4);
    chk("lui_enables", {reg_write, mem_write, jump, branch}, 0);
    chk("lui_not_yet", 32'(illegal), 0);
    tick();
    chk("illegal_set", 32'(illegal), 1);
    bubble(1);
    chk("illegal_held", 32'(illegal), 1);

    // reset mid-operation with a writer in flight
    instr(7'b0000011, 3'b011, 7'd0, 5'd1, 5'd0, 5'd5);
    tick();
    reset_n = 1'b0;
    #2;
    chk("rst2_illegal", 32'(illegal), 0);
    chk("rst2_count", 32'(stall_count), 0);
    reset_n = 1'b1;
    instr(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd7, 5'd6);
    chk("rst2_no_stale", 32'(stall_f), 0);
    tick();
    bubble(2);

    // back-to-back writer/reader pairs: 2 stall cycles per iteration
    for (int k = 1; k <= 100; k++) begin
      instr(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5);
      tick();
      instr(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd5, 5'd6);
      tick();
      tick();
      if (k == 31) begin
        chk("sat_pre", 32'(s_stall_count), 62);
        chk("cnt_pre", 32'(stall_count), 62);
      end
    end
    chk("sat_hold", 32'(s_stall_count), 63);
    chk("cnt_200", 32'(stall_count), 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
